// File: rtl/idpair_packer.sv
`default_nettype none
// ============================================================================
// Module      : idpair_packer
// Description : Pops {ref_id,cmp_id} pairs from the ID-pair producer, packs them
//               LSB-first into wide words and streams them out on valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module idpair_packer #(
    parameter  int BUS_WIDTH      = 128,
    parameter  int VEC_ID_WIDTH   = 10,
    localparam int PAIR_WIDTH     = 2 * VEC_ID_WIDTH,
    localparam int PAIRS_PER_WORD = BUS_WIDTH / PAIR_WIDTH,
    localparam int CNT_W          = $clog2(PAIRS_PER_WORD + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_IDPair_Ready,
    input  logic [PAIR_WIDTH-1:0] i_IDPair_Out,
    input  logic                  i_IDPair_Last,
    output logic                  o_IDPair_Read,
    output logic [BUS_WIDTH-1:0]  o_Data,
    output logic [CNT_W-1:0]      o_Count,
    output logic                  o_Valid,
    output logic                  o_Last,
    input  logic                  i_Ready,
    output logic [31:0]           o_PairTotal
);

    logic [BUS_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]     r_acc_cnt;
    logic                 r_acc_last;
    logic                 r_job_done;

    logic                 w_acc_pending;
    logic                 w_xfer;
    logic                 w_pop;
    logic [CNT_W-1:0]     w_base_cnt;
    logic [BUS_WIDTH-1:0] w_acc_next;
    logic [CNT_W-1:0]     w_cnt_next;
    logic                 w_last_next;

    // A word moving to the output register frees the accumulator in the same
    // cycle, so the incoming pair lands in slot 0 and the pop stream never stalls.
    always_comb begin
        w_acc_pending = (r_acc_cnt == CNT_W'(PAIRS_PER_WORD)) || r_acc_last;
        w_xfer        = w_acc_pending && (!o_Valid || i_Ready);
        o_IDPair_Read = rstn && (!w_acc_pending || w_xfer);
        w_pop         = o_IDPair_Read && i_IDPair_Ready;
        w_base_cnt    = w_xfer ? '0 : r_acc_cnt;
        w_acc_next    = w_xfer ? '0 : r_acc;
        for (int k = 0; k < PAIRS_PER_WORD; k++) begin
            if (w_pop && (w_base_cnt == CNT_W'(k))) begin
                w_acc_next[k*PAIR_WIDTH +: PAIR_WIDTH] = i_IDPair_Out;
            end
        end
        w_cnt_next  = w_pop ? (w_base_cnt + CNT_W'(1)) : w_base_cnt;
        w_last_next = w_pop ? i_IDPair_Last : (r_acc_last && !w_xfer);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc       <= '0;
            r_acc_cnt   <= '0;
            r_acc_last  <= 1'b0;
            r_job_done  <= 1'b0;
            o_Data      <= '0;
            o_Count     <= '0;
            o_Valid     <= 1'b0;
            o_Last      <= 1'b0;
            o_PairTotal <= '0;
        end else begin
            r_acc      <= w_acc_next;
            r_acc_cnt  <= w_cnt_next;
            r_acc_last <= w_last_next;

            if (w_xfer) begin
                o_Data  <= r_acc;
                o_Count <= r_acc_cnt;
                o_Last  <= r_acc_last;
                o_Valid <= 1'b1;
            end else if (o_Valid && i_Ready) begin
                o_Valid <= 1'b0;
            end

            // The first pair after a job's final pair restarts the running total.
            if (w_pop) begin
                o_PairTotal <= r_job_done ? 32'd1 : (o_PairTotal + 32'd1);
                r_job_done  <= i_IDPair_Last;
            end
        end
    end

endmodule
`default_nettype wire
